// File: rtl/rr_arb4_3_pkg.sv
// Shared constants, state encoding and one-hot helpers for the 4-way
// round-robin arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [NUM_REQ-1:0] vec);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (vec[k]) r = k[IDX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb4_3_if.sv
// Request/grant bundle between four requesting agents and the arbiter
// that drives the shared 3-bit bus.
interface rr_arb4_3_if;
    import rr_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [2:0]         data_a;
    logic [2:0]         data_b;
    logic [2:0]         data_c;
    logic [2:0]         data_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   sel;
    logic [2:0]         out;
    logic               out_vld;

    modport master (
        output req, data_a, data_b, data_c, data_d,
        input  gnt, sel, out, out_vld
    );

    modport slave (
        input  req, data_a, data_b, data_c, data_d,
        output gnt, sel, out, out_vld
    );
endinterface

// File: rtl/mux12_3.sv
// 4:1 mux of 3-bit words (12 data inputs bits to 3 output bits).
module mux12_3 (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    input  logic [2:0] c_i,
    input  logic [2:0] d_i,
    input  logic [1:0] sel_i,
    output logic [2:0] y_o
);
    always_comb begin
        y_o = a_i;
        case (sel_i)
            2'd0: y_o = a_i;
            2'd1: y_o = b_i;
            2'd2: y_o = c_i;
            2'd3: y_o = d_i;
            default: y_o = a_i;
        endcase
    end
endmodule

// File: rtl/rr_arb4_3_pick4.sv
// Combinational rotating priority pick: first set candidate bit searching
// from ptr upward, modulo 4.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;

    // rot[k] is the candidate k positions after ptr; 2-bit add wraps mod 4.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign rot[gi] = cand_i[IDX_W'(gi) + ptr_i];
    end

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = k[IDX_W-1:0];
        end
    end

    assign found_o = |rot;
    assign idx_o   = ptr_i + off;
endmodule

// File: rtl/rr_arb4_3.sv
// Round-robin arbiter sharing one 3-bit datapath between four requesters,
// with hold-while-requesting ownership and an optional hold-limit timeout.
module rr_arb4_3
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb4_3_if.slave    bus
);
    localparam int HOLD_LIM_I = (MAX_HOLD == 0) ? (2 ** HOLD_W) - 1 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_LIM_I[HOLD_W-1:0];
    localparam bit TO_EN = (MAX_HOLD != 0);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick_ptr;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               timeout;
    logic               release_w;

    // While granted, sel_q is the owner index.
    assign others    = bus.req & ~onehot(sel_q);
    assign next_ptr  = sel_q + 1'b1;
    assign timeout   = TO_EN && (hold_q == HOLD_LIM) && (|others);
    assign release_w = !bus.req[sel_q] || timeout;

    // One picker serves both IDLE and release: after a release the search
    // starts just past the old owner and excludes it.
    assign cand     = (state_q == ST_GRANT) ? others   : bus.req;
    assign pick_ptr = (state_q == ST_GRANT) ? next_ptr : ptr_q;

    rr_pick4 u_pick (
        .cand_i  (cand),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(pick_idx);
                    sel_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (release_w) begin
                    ptr_d = next_ptr;
                    if (pick_found) begin
                        gnt_d  = onehot(pick_idx);
                        sel_d  = pick_idx;
                        hold_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.out_vld = |gnt_q;

    mux12_3 u_mux (
        .a_i   (bus.data_a),
        .b_i   (bus.data_b),
        .c_i   (bus.data_c),
        .d_i   (bus.data_d),
        .sel_i (sel_q),
        .y_o   (bus.out)
    );

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_vld_match   : assert property (@(posedge clk) disable iff (!rst_n) bus.out_vld == (|gnt_q));
    a_sel_match   : assert property (@(posedge clk) disable iff (!rst_n)
                                     (gnt_q != '0) |-> (sel_q == encode(gnt_q)));
endmodule

// File: tb/tb_rr_arb4_3.sv
// Directed bench for rr_arb4_3: a vector table for the main sequence plus
// hand-written sequences for reset, round robin, lone-owner and same-edge cases.
module tb_rr_arb4_3;
    logic clk;
    logic rst_n;

    rr_arb4_3_if bus_if ();

    rr_arb4_3 #(.MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [2:0] out;
        logic       vld;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_if.req = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic show(input string tag);
        $display("%s req=%b gnt=%b sel=%0d out=%b vld=%b", tag,
                 bus_if.req, bus_if.gnt, bus_if.sel, bus_if.out, bus_if.out_vld);
    endtask

    initial begin
        // sel -> out: 0:011 1:110 2:101 3:010
        bus_if.data_a = 3'b011;
        bus_if.data_b = 3'b110;
        bus_if.data_c = 3'b101;
        bus_if.data_d = 3'b010;
        bus_if.req    = 4'b0000;
        rst_n         = 1'b0;

        vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 3'b011, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 3'b101, 1'b1};
        vecs[2]  = '{4'b0000, 4'b0000, 2'd2, 3'b101, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1000, 2'd3, 3'b010, 1'b1};
        vecs[4]  = '{4'b0111, 4'b0001, 2'd0, 3'b011, 1'b1};
        vecs[5]  = '{4'b0110, 4'b0010, 2'd1, 3'b110, 1'b1};
        vecs[6]  = '{4'b0100, 4'b0100, 2'd2, 3'b101, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 2'd2, 3'b101, 1'b0};
        vecs[8]  = '{4'b0011, 4'b0001, 2'd0, 3'b011, 1'b1};
        vecs[9]  = '{4'b0011, 4'b0001, 2'd0, 3'b011, 1'b1};
        vecs[10] = '{4'b0011, 4'b0001, 2'd0, 3'b011, 1'b1};
        vecs[11] = '{4'b0011, 4'b0001, 2'd0, 3'b011, 1'b1};
        vecs[12] = '{4'b0011, 4'b0010, 2'd1, 3'b110, 1'b1};
        vecs[13] = '{4'b0011, 4'b0010, 2'd1, 3'b110, 1'b1};
        vecs[14] = '{4'b0011, 4'b0010, 2'd1, 3'b110, 1'b1};
        vecs[15] = '{4'b0011, 4'b0010, 2'd1, 3'b110, 1'b1};
        vecs[16] = '{4'b0011, 4'b0001, 2'd0, 3'b011, 1'b1};
        vecs[17] = '{4'b0000, 4'b0000, 2'd0, 3'b011, 1'b0};

        // Reset: async clear of an active grant without a clock edge
        do_reset();
        check("rst_gnt", 32'(bus_if.gnt), 32'h0);
        check("rst_sel", 32'(bus_if.sel), 32'h0);
        check("rst_out", 32'(bus_if.out), 32'(3'b011));
        bus_if.req = 4'b0010;
        step();
        show("pre-reset grant");
        check("pre_rst_gnt", 32'(bus_if.gnt), 32'(4'b0010));
        #2 rst_n = 1'b0;
        #1;
        show("async reset");
        check("async_rst_gnt", 32'(bus_if.gnt), 32'h0);
        check("async_rst_sel", 32'(bus_if.sel), 32'h0);
        check("async_rst_vld", 32'(bus_if.out_vld), 32'h0);
        bus_if.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        check("idle_after_rst_gnt", 32'(bus_if.gnt), 32'h0);
        check("idle_after_rst_vld", 32'(bus_if.out_vld), 32'h0);

        // Table-driven main sequence starting from a fresh reset
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            bus_if.req = vecs[i].req;
            step();
            show($sformatf("vec %0d", i));
            check($sformatf("vec%0d_gnt", i), 32'(bus_if.gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_sel", i), 32'(bus_if.sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d_out", i), 32'(bus_if.out), 32'(vecs[i].out));
            check($sformatf("vec%0d_vld", i), 32'(bus_if.out_vld), 32'(vecs[i].vld));
        end

        // Round robin from reset: each owner drops one cycle after its grant
        do_reset();
        begin
            logic [3:0] rr_req [5];
            logic [3:0] rr_gnt [5];
            rr_req = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
            rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
            for (int i = 0; i < 5; i++) begin
                bus_if.req = rr_req[i];
                step();
                show($sformatf("rr %0d", i));
                check($sformatf("rr%0d_gnt", i), 32'(bus_if.gnt), 32'(rr_gnt[i]));
            end
        end

        // Lone owner: timeout never fires without a waiting requester
        do_reset();
        bus_if.req = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            step();
            show($sformatf("lone %0d", i));
            check($sformatf("lone%0d_gnt", i), 32'(bus_if.gnt), 32'(4'b1000));
        end
        check("lone_hold_sat", 32'(dut.hold_q), 32'd3);

        // Owner 1 drops as req[3] rises at the same edge: back-to-back grant
        do_reset();
        bus_if.req = 4'b0010;
        step();
        check("sim_own1", 32'(bus_if.gnt), 32'(4'b0010));
        bus_if.req = 4'b1000;
        step();
        show("same-edge handoff");
        check("sim_b2b_gnt", 32'(bus_if.gnt), 32'(4'b1000));
        check("sim_b2b_sel", 32'(bus_if.sel), 32'd3);

        // req[3] rises one cycle late: exactly one idle cycle
        do_reset();
        bus_if.req = 4'b0010;
        step();
        bus_if.req = 4'b0000;
        step();
        show("late rise idle");
        check("late_idle_gnt", 32'(bus_if.gnt), 32'h0);
        check("late_idle_sel", 32'(bus_if.sel), 32'd1);
        bus_if.req = 4'b1000;
        step();
        show("late rise grant");
        check("late_gnt", 32'(bus_if.gnt), 32'(4'b1000));
        check("late_vld", 32'(bus_if.out_vld), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
